frame_fifo_writer: RTL and testbench

FRAME_FIFO_WRITER -- requirements
Module: frame_fifo_writer

---
 rtl/frame_fifo_writer_pkg.sv | 47 ++++
 rtl/frame_fifo_writer_pixel_pos_counter.sv | 45 ++++
 rtl/frame_fifo_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_frame_fifo_writer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_fifo_writer_pkg.sv
// Shared types and constants for the frame FIFO writer.
// Optional feature macro: FRAME_HEADER_EN adds the HEADER state and its constants' use.
package frame_fifo_writer_pkg;

`ifdef FRAME_HEADER_EN
    typedef enum logic [2:0] {
        IDLE,
        FRESET,
        WAIT_SOF,
        HEADER,
        CAPTURE,
        PAD,
        DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        FRESET,
        WAIT_SOF,
        CAPTURE,
        PAD,
        DONE
    } state_t;
`endif

    // Header word payloads; only bits [9:2] of a FIFO word survive, so bytes sit there.
    localparam logic [7:0] HDR_BYTE0 = 8'hFF;
    localparam logic [7:0] HDR_BYTE1 = 8'h00;
    localparam logic [7:0] HDR_BYTE2 = 8'hFF;
    localparam int         HDR_LEN   = 4;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The fourth header byte carries the low byte of the frame counter.
    function automatic logic [7:0] header_byte(input logic [1:0] idx, input logic [7:0] count);
        case (idx)
            2'd0:    return HDR_BYTE0;
            2'd1:    return HDR_BYTE1;
            2'd2:    return HDR_BYTE2;
            default: return count;
        endcase
    endfunction

endpackage

// File: rtl/frame_fifo_writer_pixel_pos_counter.sv
// Column/line position tracker for one frame with a last-pixel flag.
module pixel_pos_counter
    import frame_fifo_writer_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic advance,
    output logic last
);

    localparam int CW = cnt_width(IMG_W);
    localparam int LW = cnt_width(IMG_H);

    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic          col_end;
    logic          line_end;

    assign col_end  = (col == CW'(IMG_W - 1));
    assign line_end = (line == LW'(IMG_H - 1));
    assign last     = col_end && line_end;

    // Step one pixel position per counted pixel, wrapping columns into lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col  <= '0;
            line <= '0;
        end else if (clear) begin
            col  <= '0;
            line <= '0;
        end else if (advance) begin
            if (col_end) begin
                col  <= '0;
                line <= line_end ? '0 : line + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_fifo_writer.sv
// Captures one camera frame into a BTPipe FIFO, padding to a whole block.
// Optional feature macro: FRAME_HEADER_EN prepends a 4-word header to each frame.
module frame_fifo_writer
    import frame_fifo_writer_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int BLOCK_LEN  = 1024,
    parameter int RST_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture_start,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  pix_data,
    input  logic        FIFO_full,
    output logic        FIFO_wr_enable,
    output logic [31:0] FIFO_data_in,
    output logic        FIFO_write_reset,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        short_frame,
    output logic [15:0] frame_count
);

    localparam int EW = cnt_width(BLOCK_LEN);
    localparam int RW = cnt_width(RST_CYCLES);

    state_t        state;
    state_t        state_next;
    logic [EW-1:0] entry_cnt;
    logic [EW-1:0] entry_next;
    logic [RW-1:0] rst_cnt;
    logic [RW-1:0] rst_cnt_next;
    logic          wr_next;
    logic [31:0]   data_next;
    logic          overflow_next;
    logic          short_next;
    logic [15:0]   count_next;
    logic          pos_clear;
    logic          pos_advance;
    logic          pos_last;

`ifdef FRAME_HEADER_EN
    logic [1:0]    hdr_idx;
    logic [1:0]    hdr_idx_next;
    logic [9:0]    held_pix;
    logic [9:0]    held_next;
    logic          held_pending;
    logic          pending_next;
`endif

    pixel_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pos_clear),
        .advance (pos_advance),
        .last    (pos_last)
    );

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // Next-state and write decision; the write itself is registered below.
    always_comb begin
        state_next    = state;
        wr_next       = 1'b0;
        data_next     = FIFO_data_in;
        entry_next    = entry_cnt;
        rst_cnt_next  = rst_cnt;
        overflow_next = overflow;
        short_next    = short_frame;
        count_next    = frame_count;
        pos_clear     = 1'b0;
        pos_advance   = 1'b0;
`ifdef FRAME_HEADER_EN
        hdr_idx_next  = hdr_idx;
        held_next     = held_pix;
        pending_next  = held_pending;
`endif
        case (state)
            IDLE: begin
                if (capture_start) begin
                    state_next    = FRESET;
                    overflow_next = 1'b0;
                    short_next    = 1'b0;
                    entry_next    = '0;
                    rst_cnt_next  = '0;
                    pos_clear     = 1'b1;
                end
            end
            FRESET: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    state_next = WAIT_SOF;
                end else begin
                    rst_cnt_next = rst_cnt + 1'b1;
                end
            end
            WAIT_SOF: begin
                if (pix_valid && frame_start) begin
`ifdef FRAME_HEADER_EN
                    held_next    = pix_data;
                    pending_next = 1'b1;
                    hdr_idx_next = '0;
                    state_next   = HEADER;
`else
                    pos_advance = 1'b1;
                    if (FIFO_full) begin
                        overflow_next = 1'b1;
                    end else begin
                        wr_next    = 1'b1;
                        data_next  = {22'b0, pix_data};
                        entry_next = entry_cnt + 1'b1;
                    end
                    state_next = pos_last ? PAD : CAPTURE;
`endif
                end
            end
`ifdef FRAME_HEADER_EN
            HEADER: begin
                if (!FIFO_full) begin
                    wr_next    = 1'b1;
                    data_next  = {22'b0, header_byte(hdr_idx, frame_count[7:0]), 2'b00};
                    entry_next = entry_cnt + 1'b1;
                    if (hdr_idx == 2'(HDR_LEN - 1)) begin
                        state_next = CAPTURE;
                    end else begin
                        hdr_idx_next = hdr_idx + 1'b1;
                    end
                end
            end
`endif
            CAPTURE: begin
`ifdef FRAME_HEADER_EN
                if (held_pending) begin
                    if (!FIFO_full) begin
                        wr_next      = 1'b1;
                        data_next    = {22'b0, held_pix};
                        entry_next   = entry_cnt + 1'b1;
                        pos_advance  = 1'b1;
                        pending_next = 1'b0;
                        if (pos_last) begin
                            state_next = PAD;
                        end
                    end
                end else
`endif
                if (pix_valid) begin
                    if (frame_start) begin
                        short_next = 1'b1;
                        state_next = PAD;
                    end else begin
                        pos_advance = 1'b1;
                        if (FIFO_full) begin
                            overflow_next = 1'b1;
                        end else begin
                            wr_next    = 1'b1;
                            data_next  = {22'b0, pix_data};
                            entry_next = entry_cnt + 1'b1;
                        end
                        if (pos_last) begin
                            state_next = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (entry_cnt == '0) begin
                    state_next = DONE;
                end else if (!FIFO_full) begin
                    wr_next    = 1'b1;
                    data_next  = '0;
                    entry_next = entry_cnt + 1'b1;
                end
            end
            DONE: begin
                count_next = frame_count + 16'd1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered FIFO interface, counters and sticky status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            FIFO_wr_enable   <= 1'b0;
            FIFO_data_in     <= '0;
            FIFO_write_reset <= 1'b1;
            entry_cnt        <= '0;
            rst_cnt          <= '0;
            overflow         <= 1'b0;
            short_frame      <= 1'b0;
            frame_count      <= '0;
        end else begin
            FIFO_wr_enable   <= wr_next;
            FIFO_data_in     <= data_next;
            FIFO_write_reset <= (state_next == FRESET);
            entry_cnt        <= entry_next;
            rst_cnt          <= rst_cnt_next;
            overflow         <= overflow_next;
            short_frame      <= short_next;
            frame_count      <= count_next;
        end
    end

`ifdef FRAME_HEADER_EN
    // Header sequencing and the start-of-frame pixel held back behind the header.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_idx      <= '0;
            held_pix     <= '0;
            held_pending <= 1'b0;
        end else begin
            hdr_idx      <= hdr_idx_next;
            held_pix     <= held_next;
            held_pending <= pending_next;
        end
    end
`endif

endmodule

// File: tb/tb_frame_fifo_writer.sv
// Randomized self-checking bench for frame_fifo_writer (IMG_W=4, IMG_H=2, BLOCK_LEN=16).
// Honours FRAME_HEADER_EN when the design is built with it.
module tb_frame_fifo_writer;

    localparam int IMG_W      = 4;
    localparam int IMG_H      = 2;
    localparam int BLOCK_LEN  = 16;
    localparam int RST_CYCLES = 8;
    localparam int NPIX       = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        capture_start = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_data = '0;
    logic        FIFO_full = 1'b0;
    logic        FIFO_wr_enable;
    logic [31:0] FIFO_data_in;
    logic        FIFO_write_reset;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        short_frame;
    logic [15:0] frame_count;

    typedef struct {
        logic       fs;
        logic [9:0] d;
        logic       full;
    } pix_t;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          wr_seen = 0;
    int          rst_hi = 0;
    int          done_cnt = 0;
    logic        last_full = 1'b0;
    logic [15:0] fc_model = '0;
    logic [31:0] exp_q[$];
    pix_t        frame_px[$];

    frame_fifo_writer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .BLOCK_LEN  (BLOCK_LEN),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .capture_start    (capture_start),
        .frame_start      (frame_start),
        .pix_valid        (pix_valid),
        .pix_data         (pix_data),
        .FIFO_full        (FIFO_full),
        .FIFO_wr_enable   (FIFO_wr_enable),
        .FIFO_data_in     (FIFO_data_in),
        .FIFO_write_reset (FIFO_write_reset),
        .busy             (busy),
        .frame_done       (frame_done),
        .overflow         (overflow),
        .short_frame      (short_frame),
        .frame_count      (frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sampleOutputs();
        if (FIFO_wr_enable) begin
            wr_seen++;
            checkOutput("wr_after_full", 32'(last_full), 32'd0);
            if (exp_q.size() > 0) begin
                checkOutput("wr_data", FIFO_data_in, exp_q.pop_front());
            end
        end
        if (FIFO_write_reset) rst_hi++;
        if (frame_done) done_cnt++;
    endtask

    task automatic applyStimulus(input logic cs, input logic v, input logic fs,
                                 input logic [9:0] d, input logic full);
        @(negedge clk);
        sampleOutputs();
        capture_start = cs;
        pix_valid     = v;
        frame_start   = fs;
        pix_data      = d;
        FIFO_full     = full;
        last_full     = full;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_wr_enable"}, 32'(FIFO_wr_enable), 32'd0);
        checkOutput({pfx, "_data_in"}, FIFO_data_in, 32'd0);
        checkOutput({pfx, "_write_reset"}, 32'(FIFO_write_reset), 32'd1);
        checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
        checkOutput({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({pfx, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({pfx, "_short_frame"}, 32'(short_frame), 32'd0);
        checkOutput({pfx, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // Reference: the FIFO content of a frame from the presented pixels (SOF first).
    task automatic modelFrame(output logic exp_ovf, output logic exp_short);
        int counted;
        counted   = 0;
        exp_ovf   = 1'b0;
        exp_short = 1'b0;
        exp_q.delete();
`ifdef FRAME_HEADER_EN
        exp_q.push_back({22'b0, 8'hFF, 2'b00});
        exp_q.push_back(32'd0);
        exp_q.push_back({22'b0, 8'hFF, 2'b00});
        exp_q.push_back({22'b0, fc_model[7:0], 2'b00});
`endif
        for (int i = 0; i < frame_px.size(); i++) begin
            if (counted == NPIX) break;
            if (i > 0 && frame_px[i].fs) begin
                exp_short = 1'b1;
                break;
            end
            if (frame_px[i].full) exp_ovf = 1'b1;
            else exp_q.push_back({22'b0, frame_px[i].d});
            counted++;
        end
        while (exp_q.size() % BLOCK_LEN != 0) exp_q.push_back(32'd0);
    endtask

    // kind 0: clean, 1: full on pixel 3, 2: frame_start on pixel 6, 3: random.
    task automatic runFrame(input int kind);
        logic exp_ovf;
        logic exp_short;
        int   total;
        int   short_at;
        pix_t p;
        frame_px.delete();
        short_at = 0;
        if (kind == 2) short_at = 5;
        else if (kind >= 3 && $urandom_range(0, 3) == 0) short_at = $urandom_range(1, NPIX - 1);
        for (int i = 0; i < NPIX + 2; i++) begin
            p.fs   = (i == 0) || (short_at != 0 && i == short_at);
            p.d    = (kind < 3) ? 10'(i + 1) : 10'($urandom);
            p.full = 1'b0;
            if (kind == 1 && i == 2) p.full = 1'b1;
            if (kind >= 3 && i > 0 && $urandom_range(0, 4) == 0) p.full = 1'b1;
            frame_px.push_back(p);
        end
        modelFrame(exp_ovf, exp_short);
        total    = exp_q.size();
        wr_seen  = 0;
        rst_hi   = 0;
        done_cnt = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        repeat (RST_CYCLES - 1)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)));
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 10'($urandom), 1'b0);

        for (int i = 0; i < frame_px.size(); i++) begin
            applyStimulus(1'b0, 1'b1, frame_px[i].fs, frame_px[i].d, frame_px[i].full);
            if (i == 0) repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
            else if (kind >= 3)
                repeat ($urandom_range(0, 1))
                    applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'($urandom_range(0, 3) == 0));
        end

        for (int c = 0; c < 400 && done_cnt == 0; c++)
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom),
                          (kind >= 3) ? 1'($urandom_range(0, 3) == 0) : 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);

        fc_model = fc_model + 16'd1;
        checkOutput("frame_done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("write_count", 32'(wr_seen), 32'(total));
        checkOutput("writes_left", 32'(exp_q.size()), 32'd0);
        checkOutput("write_reset_cycles", 32'(rst_hi), 32'(RST_CYCLES));
        checkOutput("frame_count", 32'(frame_count), 32'(fc_model));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("short_frame", 32'(short_frame), 32'(exp_short));
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    // Short frame, then reset asserted asynchronously while padding.
    task automatic abortInPad();
        exp_q.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        repeat (RST_CYCLES + 1) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd11, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd12, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd13, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        checkOutput("short_before_abort", 32'(short_frame), 32'd1);
        checkOutput("busy_in_pad", 32'(busy), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checkResetValues("abort");
        fc_model = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("write_reset_held", 32'(FIFO_write_reset), 32'd1);
        @(posedge clk);
        #1 checkOutput("write_reset_release", 32'(FIFO_write_reset), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("write_reset_first_edge", 32'(FIFO_write_reset), 32'd0);

        runFrame(0);
        runFrame(1);
        runFrame(2);
        for (int n = 0; n < 8; n++) runFrame(3);
        abortInPad();
        runFrame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
